// File: rtl/gpio_bram_arbiter.sv
// rtl/gpio_bram_arbiter.sv - round-robin arbiter/sequencer sharing one BRAM-style port between two requesters
// All outputs come straight from registers; next-state values are built in one combinational block.
module gpio_bram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  done0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic                  bram_re,
  input  logic [DATA_WIDTH-1:0] bram_rd_data,
  output logic                  busy,
  output logic                  grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  gid_q, gid_d;
  logic                  wel_q, wel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  en_q, en_d;
  logic                  bwe_q, bwe_d;
  logic                  bre_q, bre_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic                  busy_q, busy_d;
  logic                  pick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gid_d   = gid_q;
    wel_d   = wel_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    en_d    = 1'b0;
    bwe_d   = 1'b0;
    bre_d   = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    pick    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes next.
          pick    = (req0 && req1) ? ~last_q : req1;
          gid_d   = pick;
          last_d  = pick;
          wel_d   = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wd_d    = pick ? wdata1 : wdata0;
          en_d    = 1'b1;
          bwe_d   = pick ? we1 : we0;
          bre_d   = pick ? ~we1 : ~we0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wel_q) begin
          done0_d = ~gid_q;
          done1_d = gid_q;
          state_d = DONE;
        end else begin
          cnt_d   = 3'(RD_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (gid_q) rd1_d = bram_rd_data;
          else       rd0_d = bram_rd_data;
          done0_d = ~gid_q;
          done1_d = gid_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      wel_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      en_q    <= 1'b0;
      bwe_q   <= 1'b0;
      bre_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      wel_q   <= wel_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      en_q    <= en_d;
      bwe_q   <= bwe_d;
      bre_q   <= bre_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      busy_q  <= busy_d;
    end
  end

  assign done0        = done0_q;
  assign done1        = done1_q;
  assign rdata0       = rd0_q;
  assign rdata1       = rd1_q;
  assign bram_addr    = addr_q;
  assign bram_wr_data = wd_q;
  assign bram_en      = en_q;
  assign bram_we      = bwe_q;
  assign bram_re      = bre_q;
  assign busy         = busy_q;
  assign grant_id     = gid_q;

endmodule

// File: tb/tb_gpio_bram_arbiter.sv
// tb/tb_gpio_bram_arbiter.sv - bench for gpio_bram_arbiter, two instances (read latency 1 and 3)
module tb_gpio_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_s   [2][2];
  logic        we_s    [2][2];
  logic [31:0] addr_s  [2][2];
  logic [31:0] wd_s    [2][2];
  logic        done_s  [2][2];
  logic [31:0] rdata_s [2][2];
  logic [31:0] baddr_s [2];
  logic [31:0] bwd_s   [2];
  logic        en_s    [2];
  logic        bwe_s   [2];
  logic        bre_s   [2];
  logic [31:0] rd_s    [2];
  logic        busy_s  [2];
  logic        gid_s   [2];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gpio_bram_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(g == 0 ? 1 : 3)
    ) u_dut (
      .s_axi_aclk(clk), .s_axi_areset(rst),
      .req0(req_s[g][0]), .we0(we_s[g][0]), .addr0(addr_s[g][0]), .wdata0(wd_s[g][0]),
      .done0(done_s[g][0]), .rdata0(rdata_s[g][0]),
      .req1(req_s[g][1]), .we1(we_s[g][1]), .addr1(addr_s[g][1]), .wdata1(wd_s[g][1]),
      .done1(done_s[g][1]), .rdata1(rdata_s[g][1]),
      .bram_addr(baddr_s[g]), .bram_wr_data(bwd_s[g]), .bram_en(en_s[g]),
      .bram_we(bwe_s[g]), .bram_re(bre_s[g]), .bram_rd_data(rd_s[g]),
      .busy(busy_s[g]), .grant_id(gid_s[g])
    );
  end

  function automatic void check(input string nm, input int d, input logic [31:0] a,
                                input logic [31:0] e);
    n_total++;
    if (a !== e) $display("FAIL %s dut%0d actual=%h required=%h", nm, d, a, e);
    else n_pass++;
  endfunction

  // Transaction-timeline reference: each access is a grant cycle t0 plus a done cycle.
  int          lat [2] = '{1, 3};
  bit          m_valid = 1'b0;
  int          cyc = 0;
  bit          m_act  [2];
  int          m_t0   [2];
  int          m_dc   [2];
  bit          m_g    [2];
  bit          m_w    [2];
  bit          m_gid  [2];
  bit          m_last [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd   [2];
  logic [31:0] m_rd   [2][2];

  always @(negedge clk) begin
    bit en;
    bit gr;
    for (int d = 0; d < 2; d++) begin
      if (m_valid) begin
        en = m_act[d] && (cyc == m_t0[d] + 1);
        check("bram_en", d, en_s[d], en);
        check("bram_we", d, bwe_s[d], en && m_w[d]);
        check("bram_re", d, bre_s[d], en && !m_w[d]);
        check("bram_addr", d, baddr_s[d], m_addr[d]);
        check("bram_wr_data", d, bwd_s[d], m_wd[d]);
        check("busy", d, busy_s[d], m_act[d] && cyc > m_t0[d] && cyc <= m_dc[d]);
        check("done0", d, done_s[d][0], m_act[d] && cyc == m_dc[d] && !m_g[d]);
        check("done1", d, done_s[d][1], m_act[d] && cyc == m_dc[d] && m_g[d]);
        check("rdata0", d, rdata_s[d][0], m_rd[d][0]);
        check("rdata1", d, rdata_s[d][1], m_rd[d][1]);
        check("grant_id", d, gid_s[d], m_gid[d]);
      end
      if (rst) begin
        m_act[d] = 0; m_gid[d] = 0; m_last[d] = 1;
        m_addr[d] = '0; m_wd[d] = '0; m_rd[d][0] = '0; m_rd[d][1] = '0;
      end else if (m_valid) begin
        if (m_act[d] && !m_w[d] && cyc == m_dc[d] - 1) m_rd[d][m_g[d]] = rd_s[d];
        if (!m_act[d] || cyc > m_dc[d]) begin
          m_act[d] = 0;
          if (req_s[d][0] || req_s[d][1]) begin
            gr = (req_s[d][0] && req_s[d][1]) ? !m_last[d] : req_s[d][1];
            m_act[d] = 1; m_t0[d] = cyc; m_g[d] = gr; m_w[d] = we_s[d][gr];
            m_addr[d] = addr_s[d][gr]; m_wd[d] = wd_s[d][gr];
            m_gid[d] = gr; m_last[d] = gr;
            m_dc[d] = m_w[d] ? cyc + 2 : cyc + 2 + lat[d];
          end
        end
      end
    end
    if (rst) m_valid = 1'b1;
    cyc++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int cnt    [2][2];
  bit drop   [2][2];
  bit pend   [2][2];
  bit seen   [2][2];
  int last_en[2];
  int nen    [2];
  bit all_done;
  bit was_rst;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_s[d] = '0;
      for (int r = 0; r < 2; r++) begin
        req_s[d][r] = 0; we_s[d][r] = 0; addr_s[d][r] = '0; wd_s[d][r] = '0;
        cnt[d][r] = 0; drop[d][r] = 0; pend[d][r] = 0;
      end
      last_en[d] = 0; nen[d] = 0;
    end
    repeat (3) next_cycle();
    rst = 0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset bram_en", d, en_s[d], 0);
      check("reset busy", d, busy_s[d], 0);
      check("reset grant_id", d, gid_s[d], 0);
      check("reset rdata0", d, rdata_s[d][0], 0);
      check("reset bram_addr", d, baddr_s[d], 0);
    end

    // Write from requester 0, inputs changed right after the grant.
    next_cycle();
    req_s[0][0] = 1; we_s[0][0] = 1; addr_s[0][0] = 32'h10; wd_s[0][0] = 32'hA5A5_0001;
    next_cycle();
    addr_s[0][0] = 32'h99; wd_s[0][0] = 32'h1234_5678;
    @(negedge clk);
    check("t1 bram_en", 0, en_s[0], 1);
    check("t1 bram_we", 0, bwe_s[0], 1);
    check("t1 bram_re", 0, bre_s[0], 0);
    check("t1 bram_addr", 0, baddr_s[0], 32'h10);
    check("t1 bram_wr_data", 0, bwd_s[0], 32'hA5A5_0001);
    next_cycle();
    @(negedge clk);
    check("t1 done0", 0, done_s[0][0], 1);
    check("t1 done1", 0, done_s[0][1], 0);
    check("t6 bram_addr held", 0, baddr_s[0], 32'h10);
    check("t6 bram_wr_data held", 0, bwd_s[0], 32'hA5A5_0001);
    next_cycle();
    req_s[0][0] = 0;

    // Read from requester 1, latency 1.
    next_cycle();
    req_s[0][1] = 1; we_s[0][1] = 0; addr_s[0][1] = 32'h04;
    next_cycle();
    @(negedge clk);
    check("t2 bram_re", 0, bre_s[0], 1);
    check("t2 bram_we", 0, bwe_s[0], 0);
    check("t2 bram_addr", 0, baddr_s[0], 32'h04);
    next_cycle();
    rd_s[0] = 32'hFF;
    next_cycle();
    rd_s[0] = '0;
    @(negedge clk);
    check("t2 done1", 0, done_s[0][1], 1);
    check("t2 rdata1", 0, rdata_s[0][1], 32'hFF);
    check("t2 rdata0", 0, rdata_s[0][0], 0);
    next_cycle();
    req_s[0][1] = 0;

    // Read from requester 0, latency 3, data valid only in cycle 4.
    next_cycle();
    req_s[1][0] = 1; we_s[1][0] = 0; addr_s[1][0] = 32'h08; rd_s[1] = 32'hDEAD_BEEF;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      rd_s[1] = (k == 4) ? 32'h1234_ABCD : 32'hDEAD_BEEF;
      @(negedge clk);
      if (k == 4) check("t4 done0 early", 1, done_s[1][0], 0);
      if (k == 5) begin
        check("t4 done0", 1, done_s[1][0], 1);
        check("t4 rdata0", 1, rdata_s[1][0], 32'h1234_ABCD);
      end
    end
    next_cycle();
    req_s[1][0] = 0; rd_s[1] = '0;

    // Reset during WAIT, then both requesters write continuously.
    next_cycle();
    req_s[1][1] = 1; we_s[1][1] = 0; addr_s[1][1] = 32'h20;
    next_cycle();
    next_cycle();
    rst = 1;
    @(negedge clk);
    check("t5 busy in wait", 1, busy_s[1], 1);
    next_cycle();
    rst = 0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) begin
        req_s[d][r] = 1; we_s[d][r] = 1;
        addr_s[d][r] = 32'h100 + 32'(d * 16 + r * 4); wd_s[d][r] = 32'hC0DE_0000 + 32'(d * 2 + r);
      end
    @(negedge clk);
    check("t5 bram_en", 1, en_s[1], 0);
    check("t5 busy", 1, busy_s[1], 0);
    check("t5 done1", 1, done_s[1][1], 0);
    check("t5 rdata0", 1, rdata_s[1][0], 0);
    check("t5 grant_id", 1, gid_s[1], 0);
    all_done = 0;
    for (int k = 4; k < 60 && !all_done; k++) begin
      next_cycle();
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 2; r++)
          if (drop[d][r]) req_s[d][r] = 0;
      @(negedge clk);
      all_done = 1;
      for (int d = 0; d < 2; d++) begin
        if (en_s[d]) begin
          check("t3 grant order", d, gid_s[d], 32'(nen[d] % 2));
          if (nen[d] > 0) check("t3 en spacing", d, k - last_en[d], 3);
          last_en[d] = k;
          nen[d]++;
        end
        for (int r = 0; r < 2; r++) begin
          if (done_s[d][r]) begin
            check("t3 grant_id at done", d, gid_s[d], r);
            cnt[d][r]++;
            if (cnt[d][r] == 4) drop[d][r] = 1;
          end
          if (cnt[d][r] < 4) all_done = 0;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      check("t3 grant count", d, nen[d], 8);
      for (int r = 0; r < 2; r++) req_s[d][r] = 0;
    end
    repeat (5) next_cycle();

    // Randomized traffic with occasional resets and post-grant input changes.
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      was_rst = rst;
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 2; r++) seen[d][r] = done_s[d][r];
      next_cycle();
      rst = ($urandom_range(0, 299) == 0);
      for (int d = 0; d < 2; d++) begin
        rd_s[d] = $urandom;
        for (int r = 0; r < 2; r++) begin
          if (was_rst) begin
            pend[d][r] = 0; req_s[d][r] = 0;
          end else if ((pend[d][r] && seen[d][r] && $urandom_range(0, 1) == 0) ||
                       (!pend[d][r] && $urandom_range(0, 2) == 0)) begin
            pend[d][r] = 1; req_s[d][r] = 1; we_s[d][r] = 1'($urandom_range(0, 1));
            addr_s[d][r] = $urandom; wd_s[d][r] = $urandom;
          end else if (pend[d][r] && seen[d][r]) begin
            pend[d][r] = 0; req_s[d][r] = 0;
          end else if (pend[d][r]) begin
            if ($urandom_range(0, 7) == 0) begin
              addr_s[d][r] = $urandom; wd_s[d][r] = $urandom;
            end
            if (busy_s[d] && gid_s[d] == r && $urandom_range(0, 19) == 0) req_s[d][r] = 0;
          end
        end
      end
    end
    rst = 0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) req_s[d][r] = 0;
    repeat (10) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpio_bram_arbiter.md
Name: gpio_bram_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the GPIO register-file (BRAM-style) port.
- Shares one bram_* port between requester 0 (AXI-lite slave interface) and requester 1 (internal agent, e.g. interrupt/debounce logic).
- Round-robin grant; one access in flight at a time.
- Sequences each access (issue, read-latency wait, completion pulse) and returns read data to the granted requester.

Parameters:
ADDR_WIDTH, 32, width of requester and bram addresses
DATA_WIDTH, 32, width of write/read data
RD_LATENCY, 1, cycles from bram_en-high cycle to bram_rd_data valid; legal range 1..4

Ports:
s_axi_aclk  in  1  single clock, rising edge
s_axi_areset  in  1  reset, synchronous, active-high
req0  in  1  requester 0 access request; held until done0
we0  in  1  requester 0: 1=write, 0=read; stable while req0
addr0  in  ADDR_WIDTH  requester 0 address; stable while req0
wdata0  in  DATA_WIDTH  requester 0 write data; stable while req0
done0  out  1  one-cycle completion pulse to requester 0
rdata0  out  DATA_WIDTH  requester 0 read data; valid with done0 on reads, held until next read completion
req1/we1/addr1/wdata1/done1/rdata1  same as requester 0, for requester 1
bram_addr  out  ADDR_WIDTH  registered address to register file
bram_wr_data  out  DATA_WIDTH  registered write data
bram_en  out  1  access strobe, one cycle per access
bram_we  out  1  write strobe, equals bram_en on writes
bram_re  out  1  read strobe, equals bram_en on reads
bram_rd_data  in  DATA_WIDTH  read data, valid RD_LATENCY cycles after bram_en cycle
busy  out  1  high in every state except IDLE
grant_id  out  1  requester currently or last granted

Behaviour:
- One clock, s_axi_aclk. Reset s_axi_areset is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - bram_* outputs 0; done0, done1, rdata0, rdata1 = 0; busy 0.
  - grant_id 0; internal last_grant 1, so requester 0 wins the first tie.
  - State IDLE; wait counter 0.
- States:
  - IDLE:
    - Sample req0/req1.
    - Neither asserted: stay.
    - Exactly one asserted: grant it.
    - Both asserted: grant the requester != last_grant.
    - On grant: latch we/addr/wdata into bram_addr/bram_wr_data, set grant_id, update last_grant, go to ISSUE.
  - ISSUE (1 cycle):
    - bram_en=1; bram_we=we; bram_re=!we.
    - Write: go to DONE. Read: load counter with RD_LATENCY, go to WAIT.
    - bram_en/we/re are 0 in every other state.
  - WAIT:
    - Decrement counter each cycle.
    - In the cycle the counter equals 1, capture bram_rd_data into rdata of grant_id, then go to DONE.
    - WAIT therefore lasts exactly RD_LATENCY cycles.
  - DONE (1 cycle):
    - done of grant_id = 1 for this cycle only.
    - Arbitration is blocked this cycle. Next state IDLE.
- Latency, counting from the IDLE cycle in which the request is sampled (cycle 0):
  - Write: bram_en in cycle 1, done in cycle 2.
  - Read: bram_en in cycle 1, done in cycle 2+RD_LATENCY.
- Throughput:
  - Requester rule: deassert req at the edge where done is seen, or keep it high to request again.
  - Minimum spacing: write 3 cycles per access, read 3+RD_LATENCY cycles.
- Fairness:
  - With both requesters continuously requesting, grants strictly alternate 0,1,0,1.
  - A single requester may be granted back-to-back when the other is idle.
- req, we, addr and wdata changes after the grant are ignored until DONE; values are latched at grant.
- bram_addr and bram_wr_data hold their last values when idle.
- rdata of the non-granted requester is never modified.
- Writes never modify rdata0/rdata1.
- A requester dropping req before done is a protocol violation; the access still completes and done still pulses.
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - An in-flight access produces no done pulse.
  - A BRAM read already in flight is discarded.
- Counter wrap: RD_LATENCY outside 1..4 is illegal; the counter width is 3 bits.

Test Plan:
1. Write, requester 0: req0=1, we0=1, addr0=0x10, wdata0=0xA5A5_0001 -> cycle 1: bram_en=1, bram_we=1, bram_re=0, bram_addr=0x10, bram_wr_data=0xA5A5_0001; cycle 2: done0=1, done1=0.
2. Read, requester 1, RD_LATENCY=1: req1=1, we1=0, addr1=0x04, bram_rd_data=0x0000_00FF in cycle 2 -> bram_re=1 in cycle 1; done1=1 in cycle 3; rdata1=0xFF; rdata0 unchanged.
3. Simultaneous continuous requests, 4 writes each, out of reset -> grant order 0,1,0,1,0,1,0,1; exactly one bram_en every 3 cycles; grant_id matches each done.
4. RD_LATENCY=3 read, addr=0x08, data valid only in cycle 4 (other cycles 0xDEAD_BEEF) -> done0 in cycle 5, rdata0 equals the cycle-4 data.
5. Reset mid-read: assert s_axi_areset during WAIT -> next cycle all outputs 0 and busy=0; no done pulse; first request after reset granted to requester 0 on a tie.
6. Input change after grant: change addr0 and wdata0 in cycle 1 of a write -> bram_addr and bram_wr_data keep the values latched at grant.
